fdma_rw_arbiter: RTL and testbench
==================================

Name: fdma_rw_arbiter

Overview:
- Sits directly downstream of the four-channel splicer.
- Merges the splicer's aggregated FDMA write channel (fdma_w*) and its display read channel (fdma_r*) onto the single request/response FDMA port of the SDRAM controller.
- The SDRAM is single-ported, so write and read bursts are serialized with one burst in flight at a time.
- Grant selection is round-robin or read-priority.

Parameters:
- AXI_DATA_WIDTH, 32, FDMA data width.
- AXI_ADDR_WIDTH, 21, FDMA address width.
- RD_PRIORITY, 0, 0 = round-robin on contention, 1 = read always wins.
- REQ_TIMEOUT, 1023, maximum cycles in REQ waiting for fdma_busy before the request is aborted.

Ports:
- ui_clk  in  1  clock; every port is synchronous to it.
- ui_rstn  in  1  synchronous active-low reset.
- s_waddr  in  AXI_ADDR_WIDTH  write-channel burst address.
- s_wareq  in  1  write-channel request, level.
- s_wsize  in  16  write-channel burst length in beats.
- s_wbusy  out  1  write channel granted / in progress.
- s_wdata  in  AXI_DATA_WIDTH  write data from the upstream buffer.
- s_wvalid  out  1  write beat strobe to the upstream buffer.
- s_raddr  in  AXI_ADDR_WIDTH  read-channel burst address.
- s_rareq  in  1  read-channel request, level.
- s_rsize  in  16  read-channel burst length in beats.
- s_rbusy  out  1  read channel granted / in progress.
- s_rdata  out  AXI_DATA_WIDTH  read data to the upstream buffer.
- s_rvalid  out  1  read beat strobe to the upstream buffer.
- m_addr  out  AXI_ADDR_WIDTH  latched burst address.
- m_areq  out  1  request to the controller.
- m_wr  out  1  1 = write burst, 0 = read burst.
- m_size  out  16  latched burst length.
- m_busy  in  1  controller is executing the burst.
- m_wdata  out  AXI_DATA_WIDTH  write data to the controller.
- m_wvalid  in  1  controller write-beat strobe.
- m_rdata  in  AXI_DATA_WIDTH  read data from the controller.
- m_rvalid  in  1  controller read-beat strobe.
- err_len  out  1  sticky: a burst ended with beat count != size.
- err_timeout  out  1  sticky: a REQ_TIMEOUT expired.

Behaviour:
- Reset (ui_rstn=0 at a ui_clk edge): the following are all 0.
  - State = IDLE.
  - m_areq, m_wr, m_addr, m_size.
  - s_wbusy, s_rbusy.
  - err_len, err_timeout, the beat counter and the timeout counter.
  - last_grant = WRITE, so the first contended grant goes to read.
  - Reset mid-burst drops m_areq and the busies in the same edge. The in-flight burst is abandoned, with no recovery.
- States: IDLE, REQ, XFER, DONE.
- IDLE → REQ when either request is high.
  - Only one request high: grant it.
  - Both high, RD_PRIORITY=1: grant read.
  - Both high, RD_PRIORITY=0: grant the channel opposite to last_grant.
  - In the same edge: latch addr/size/dir into m_addr/m_size/m_wr, set the granted s_*busy=1, set m_areq=1 and update last_grant.
- Zero-size request (size=0): granted, and s_*busy pulses for exactly one cycle (IDLE→DONE). m_areq is not asserted and no error is flagged.
- REQ: m_areq held.
  - m_busy=1 → XFER, with m_areq=0 in the same edge.
  - If the timeout counter reaches REQ_TIMEOUT → DONE, set err_timeout, m_areq=0.
- XFER: the beat counter increments on each gated valid.
  - m_busy=0 → DONE.
  - If the beat count != m_size at that edge, set err_len.
- DONE: one cycle, with granted s_*busy still 1 so the requester sees busy before release. Then go to IDLE with busy=0 and counters cleared.
- Upstream s_*busy is high from the grant edge through DONE. Requesters drop their request on seeing busy; a request still high on return to IDLE starts a new arbitration.
- Datapath (combinational, zero latency):
  - m_wdata = s_wdata.
  - s_wvalid = m_wvalid & grant_w & (state==XFER).
  - s_rdata = m_rdata (broadcast).
  - s_rvalid = m_rvalid & grant_r & (state==XFER).
  - m_wvalid/m_rvalid outside XFER or for the ungranted direction are ignored and not counted.
- A new request arriving during REQ/XFER/DONE has no effect until IDLE; there is no preemption.
- Beat counter: 16 bit, saturating at 0xFFFF.

Test Plan:
- Lone write, addr 0x00400, size 256, controller raises m_busy 3 cycles after m_areq and gives 256 m_wvalid → m_wr=1, m_addr=0x00400, s_wbusy high from grant through DONE, 256 s_wvalid, err_len=0.
- s_wareq and s_rareq rise in the same cycle, RD_PRIORITY=0, after reset → read granted first, write next; on repeat contention the order alternates R,W,R,W. With RD_PRIORITY=1 → read always first.
- Read burst of size 512 where the controller delivers 511 m_rvalid then drops m_busy → err_len=1 sticky; the next clean burst leaves it set.
- m_busy never rises, REQ_TIMEOUT=15 → m_areq drops exactly 15 cycles after entry to REQ, err_timeout=1, the arbiter returns to IDLE and accepts the next request.
- s_wsize=0 request → s_wbusy high 1 cycle, m_areq stays 0.
- ui_rstn=0 for one cycle mid-XFER → m_areq, s_*busy and the errors are all 0 on the next cycle; spurious m_wvalid after reset yields s_wvalid=0.

Source files
------------

// File: rtl/fdma_rw_arbiter.sv
// Serialises the splicer's FDMA write and read channels onto the single SDRAM controller port, one burst at a time.
// Grant and control are registered (one edge from request to m_areq); data and beat strobes are combinational pass-through.
// No backpressure beyond the busy handshake: a requester waits for s_*busy, and the controller paces beats via m_*valid.
module fdma_rw_arbiter #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 21,
    parameter bit RD_PRIORITY    = 1'b0,
    parameter int REQ_TIMEOUT    = 1023
) (
    input  logic                      ui_clk,
    input  logic                      ui_rstn,
    input  logic [AXI_ADDR_WIDTH-1:0] s_waddr,
    input  logic                      s_wareq,
    input  logic [15:0]               s_wsize,
    output logic                      s_wbusy,
    input  logic [AXI_DATA_WIDTH-1:0] s_wdata,
    output logic                      s_wvalid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_raddr,
    input  logic                      s_rareq,
    input  logic [15:0]               s_rsize,
    output logic                      s_rbusy,
    output logic [AXI_DATA_WIDTH-1:0] s_rdata,
    output logic                      s_rvalid,
    output logic [AXI_ADDR_WIDTH-1:0] m_addr,
    output logic                      m_areq,
    output logic                      m_wr,
    output logic [15:0]               m_size,
    input  logic                      m_busy,
    output logic [AXI_DATA_WIDTH-1:0] m_wdata,
    input  logic                      m_wvalid,
    input  logic [AXI_DATA_WIDTH-1:0] m_rdata,
    input  logic                      m_rvalid,
    output logic                      err_len,
    output logic                      err_timeout
);

    localparam int TW = (REQ_TIMEOUT < 2) ? 1 : $clog2(REQ_TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(REQ_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            grant_vld;
    logic            grant_w;
    logic            timeout_evt;
    logic            len_evt;
    logic            beat_vld;
    logic            last_grant_w;
    logic [15:0]     size_sel;
    logic [15:0]     beat_cnt;
    logic [15:0]     beat_inc;
    logic [TW-1:0]   to_cnt;

    assign m_wdata  = s_wdata;
    assign s_rdata  = m_rdata;
    assign s_wvalid = m_wvalid & s_wbusy & (state == XFER);
    assign s_rvalid = m_rvalid & s_rbusy & (state == XFER);
    assign beat_vld = s_wvalid | s_rvalid;
    assign beat_inc = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + {15'd0, beat_vld};

    // Write wins when alone; on contention read wins outright or takes turns with write.
    assign grant_w  = s_wareq & (!s_rareq | (!RD_PRIORITY & !last_grant_w));
    assign size_sel = grant_w ? s_wsize : s_rsize;

    always_ff @(posedge ui_clk) begin
        if (!ui_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_vld   = 1'b0;
        timeout_evt = 1'b0;
        len_evt     = 1'b0;
        case (state)
            IDLE: begin
                if (s_wareq | s_rareq) begin
                    grant_vld = 1'b1;
                    state_nxt = (size_sel == 16'd0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (m_busy) begin
                    state_nxt = XFER;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt   = DONE;
                    timeout_evt = 1'b1;
                end
            end
            XFER: begin
                if (!m_busy) begin
                    state_nxt = DONE;
                    len_evt   = (beat_inc != m_size);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (!ui_rstn) begin
            m_areq       <= 1'b0;
            m_wr         <= 1'b0;
            m_addr       <= '0;
            m_size       <= '0;
            s_wbusy      <= 1'b0;
            s_rbusy      <= 1'b0;
            err_len      <= 1'b0;
            err_timeout  <= 1'b0;
            beat_cnt     <= '0;
            to_cnt       <= '0;
            last_grant_w <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        m_addr       <= grant_w ? s_waddr : s_raddr;
                        m_size       <= size_sel;
                        m_wr         <= grant_w;
                        m_areq       <= (size_sel != 16'd0);
                        s_wbusy      <= grant_w;
                        s_rbusy      <= !grant_w;
                        last_grant_w <= grant_w;
                    end
                end
                REQ: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (state_nxt != REQ) begin
                        m_areq <= 1'b0;
                    end
                    if (timeout_evt) begin
                        err_timeout <= 1'b1;
                    end
                end
                XFER: begin
                    beat_cnt <= beat_inc;
                    if (len_evt) begin
                        err_len <= 1'b1;
                    end
                end
                DONE: begin
                    m_areq   <= 1'b0;
                    s_wbusy  <= 1'b0;
                    s_rbusy  <= 1'b0;
                    beat_cnt <= '0;
                    to_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fdma_rw_arbiter.sv
// Directed bench: two arbiters (round-robin and read-priority) share stimulus; controller behaviour is scripted inline.
module tb_fdma_rw_arbiter;

    localparam int DW = 32;
    localparam int AW = 21;

    logic          ui_clk = 1'b0;
    logic          ui_rstn;
    logic [AW-1:0] s_waddr, s_raddr;
    logic          s_wareq, s_rareq;
    logic [15:0]   s_wsize, s_rsize;
    logic [DW-1:0] s_wdata, m_rdata;
    logic          m_busy, m_wvalid, m_rvalid;

    logic          s_wbusy, s_wvalid, s_rbusy, s_rvalid, m_areq, m_wr, err_len, err_timeout;
    logic [DW-1:0] s_rdata, m_wdata;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_size;

    logic          p_wbusy, p_wvalid, p_rbusy, p_rvalid, p_areq, p_wr, p_err_len, p_err_timeout;
    logic [DW-1:0] p_rdata, p_wdata;
    logic [AW-1:0] p_addr;
    logic [15:0]   p_size;

    int vectors     = 0;
    int miscompares = 0;

    always #5 ui_clk = ~ui_clk;

    fdma_rw_arbiter #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .RD_PRIORITY(1'b0), .REQ_TIMEOUT(15)) u_rr (
        .ui_clk(ui_clk), .ui_rstn(ui_rstn),
        .s_waddr(s_waddr), .s_wareq(s_wareq), .s_wsize(s_wsize), .s_wbusy(s_wbusy),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid),
        .s_raddr(s_raddr), .s_rareq(s_rareq), .s_rsize(s_rsize), .s_rbusy(s_rbusy),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid),
        .m_addr(m_addr), .m_areq(m_areq), .m_wr(m_wr), .m_size(m_size), .m_busy(m_busy),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
        .err_len(err_len), .err_timeout(err_timeout)
    );

    fdma_rw_arbiter #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .RD_PRIORITY(1'b1), .REQ_TIMEOUT(15)) u_rp (
        .ui_clk(ui_clk), .ui_rstn(ui_rstn),
        .s_waddr(s_waddr), .s_wareq(s_wareq), .s_wsize(s_wsize), .s_wbusy(p_wbusy),
        .s_wdata(s_wdata), .s_wvalid(p_wvalid),
        .s_raddr(s_raddr), .s_rareq(s_rareq), .s_rsize(s_rsize), .s_rbusy(p_rbusy),
        .s_rdata(p_rdata), .s_rvalid(p_rvalid),
        .m_addr(p_addr), .m_areq(p_areq), .m_wr(p_wr), .m_size(p_size), .m_busy(m_busy),
        .m_wdata(p_wdata), .m_wvalid(m_wvalid), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
        .err_len(p_err_len), .err_timeout(p_err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge ui_clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cnt;
        int n;
        bit found;

        ui_rstn  = 1'b0;
        s_waddr  = '0; s_raddr = '0;
        s_wareq  = 1'b0; s_rareq = 1'b0;
        s_wsize  = '0; s_rsize = '0;
        s_wdata  = '0; m_rdata = '0;
        m_busy   = 1'b0; m_wvalid = 1'b0; m_rvalid = 1'b0;
        step(2);
        ui_rstn = 1'b1;

        check("rst_m_areq", {31'd0, m_areq}, 32'd0);
        check("rst_m_wr", {31'd0, m_wr}, 32'd0);
        check("rst_m_addr", {11'd0, m_addr}, 32'd0);
        check("rst_m_size", {16'd0, m_size}, 32'd0);
        check("rst_busy", {30'd0, s_wbusy, s_rbusy}, 32'd0);
        check("rst_errs", {30'd0, err_len, err_timeout}, 32'd0);

        // Contention with zero-size bursts: round-robin goes R,W,R,W; read-priority always R.
        for (int r = 0; r < 4; r++) begin
            s_wareq = 1'b1; s_rareq = 1'b1;
            step();
            check($sformatf("rr_grant_r%0d", r), {30'd0, s_rbusy, s_wbusy}, (r % 2 == 0) ? 32'd2 : 32'd1);
            check($sformatf("rp_grant_r%0d", r), {30'd0, p_rbusy, p_wbusy}, 32'd2);
            check($sformatf("zero_areq_r%0d", r), {31'd0, m_areq}, 32'd0);
            s_wareq = 1'b0; s_rareq = 1'b0;
            step();
            check($sformatf("zero_release_r%0d", r), {30'd0, s_rbusy, s_wbusy}, 32'd0);
        end

        // Lone write of 256 beats, controller answers 3 cycles after m_areq.
        s_waddr = 21'h00400; s_wsize = 16'd256; s_wareq = 1'b1;
        step();
        s_wareq = 1'b0;
        check("wr_m_wr", {31'd0, m_wr}, 32'd1);
        check("wr_m_addr", {11'd0, m_addr}, 32'h400);
        check("wr_m_size", {16'd0, m_size}, 32'd256);
        check("wr_m_areq", {31'd0, m_areq}, 32'd1);
        check("wr_busy_grant", {31'd0, s_wbusy}, 32'd1);
        m_wvalid = 1'b1;
        #1;
        check("wr_strobe_in_req", {31'd0, s_wvalid}, 32'd0);
        m_wvalid = 1'b0;
        step(2);
        m_busy = 1'b1;
        step();
        check("wr_areq_drop", {31'd0, m_areq}, 32'd0);
        cnt = 0;
        m_wvalid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            s_wdata = 32'hA5A5_0000 + i;
            #1;
            if (s_wvalid) cnt++;
            if (i == 17) check("wr_wdata_pass", m_wdata, 32'hA5A5_0011);
            step();
        end
        m_wvalid = 1'b0; m_busy = 1'b0;
        check("wr_beats", cnt, 32'd256);
        step();
        check("wr_busy_done", {31'd0, s_wbusy}, 32'd1);
        check("wr_err_len", {31'd0, err_len}, 32'd0);
        step();
        check("wr_busy_idle", {31'd0, s_wbusy}, 32'd0);

        // Short read: 511 beats for size 512 sets a sticky length error.
        s_raddr = 21'h01000; s_rsize = 16'd512; s_rareq = 1'b1;
        step();
        s_rareq = 1'b0;
        check("rd_m_wr", {31'd0, m_wr}, 32'd0);
        check("rd_busy", {30'd0, s_rbusy, s_wbusy}, 32'd2);
        m_busy = 1'b1;
        step();
        cnt = 0;
        m_rvalid = 1'b1;
        for (int i = 0; i < 511; i++) begin
            m_rdata = 32'h5A00_0000 + i;
            m_wvalid = (i == 3);
            #1;
            if (s_rvalid) cnt++;
            if (i == 3) begin
                check("rd_wstrobe_ignored", {31'd0, s_wvalid}, 32'd0);
                check("rd_rdata_pass", s_rdata, 32'h5A00_0003);
            end
            step();
        end
        m_rvalid = 1'b0; m_wvalid = 1'b0; m_busy = 1'b0;
        check("rd_beats", cnt, 32'd511);
        step();
        check("rd_err_len", {31'd0, err_len}, 32'd1);
        step();

        // A clean 4-beat write afterwards leaves the length error set.
        s_wsize = 16'd4; s_wareq = 1'b1;
        step();
        s_wareq = 1'b0; m_busy = 1'b1;
        step();
        m_wvalid = 1'b1;
        step(4);
        m_wvalid = 1'b0; m_busy = 1'b0;
        step(2);
        check("clean_err_len_sticky", {31'd0, err_len}, 32'd1);
        check("clean_busy_idle", {31'd0, s_wbusy}, 32'd0);

        // Controller never responds: m_areq must fall exactly 15 cycles after entering REQ.
        s_wsize = 16'd8; s_wareq = 1'b1;
        step();
        s_wareq = 1'b0;
        check("to_areq_up", {31'd0, m_areq}, 32'd1);
        n = 0; found = 1'b0;
        for (int i = 1; i <= 40 && !found; i++) begin
            step();
            if (!m_areq) begin
                n = i;
                found = 1'b1;
            end
        end
        check("to_cycles", n, 32'd15);
        check("to_err", {31'd0, err_timeout}, 32'd1);
        check("to_busy_done", {31'd0, s_wbusy}, 32'd1);
        step();
        check("to_busy_idle", {31'd0, s_wbusy}, 32'd0);

        s_rsize = 16'd2; s_rareq = 1'b1;
        step();
        s_rareq = 1'b0;
        check("to_next_grant", {30'd0, s_rbusy, m_areq}, 32'd3);
        m_busy = 1'b1;
        step();
        m_rvalid = 1'b1;
        step(2);
        m_rvalid = 1'b0; m_busy = 1'b0;
        step(2);
        check("to_err_sticky", {31'd0, err_timeout}, 32'd1);

        // Reset pulse in the middle of a write transfer.
        s_wsize = 16'd8; s_wareq = 1'b1;
        step();
        s_wareq = 1'b0; m_busy = 1'b1;
        step();
        m_wvalid = 1'b1;
        step(3);
        ui_rstn = 1'b0;
        step();
        check("mid_rst_areq", {31'd0, m_areq}, 32'd0);
        check("mid_rst_busy", {30'd0, s_wbusy, s_rbusy}, 32'd0);
        check("mid_rst_errs", {30'd0, err_len, err_timeout}, 32'd0);
        ui_rstn = 1'b1;
        step();
        check("post_rst_wvalid", {31'd0, s_wvalid}, 32'd0);
        check("post_rst_busy", {31'd0, s_wbusy}, 32'd0);
        m_wvalid = 1'b0; m_busy = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
